// File: rtl/mmu_paged_if.sv
// Request/response and page-table write bus of the paging MMU.
// master = CPU/kernel side, slave = MMU.
interface mmu_paged_if #(
  parameter int unsigned VADDR_W   = 16,
  parameter int unsigned PAGE_BITS = 11,
  parameter int unsigned PADDR_W   = 18,
  parameter int unsigned PTB_W     = 12
) ();
  localparam int unsigned PPN_W = PADDR_W - PAGE_BITS;

  logic               req_valid;
  logic               req_ready;
  logic [VADDR_W-1:0] req_addr;
  logic               req_write;
  logic               priv_lv;
  logic [PTB_W-1:0]   ptb;
  logic               resp_valid;
  logic               resp_ready;
  logic [PADDR_W-1:0] resp_addr;
  logic               resp_fault;
  logic [1:0]         resp_code;
  logic               pt_we;
  logic [PTB_W-1:0]   pt_waddr;
  logic [PPN_W+1:0]   pt_wdata;

  modport master (
    output req_valid, req_addr, req_write, priv_lv, ptb, resp_ready, pt_we, pt_waddr, pt_wdata,
    input  req_ready, resp_valid, resp_addr, resp_fault, resp_code
  );

  modport slave (
    input  req_valid, req_addr, req_write, priv_lv, ptb, resp_ready, pt_we, pt_waddr, pt_wdata,
    output req_ready, resp_valid, resp_addr, resp_fault, resp_code
  );
endinterface

// File: rtl/mmu_paged.sv
// Single-level paging MMU with run-time table writes, valid/writable faults and a registered
// valid/ready response. Define MMU_FAULT_REG_EN to add the sticky fault address register.
module mmu_paged #(
  parameter int unsigned VADDR_W   = 16,
  parameter int unsigned PAGE_BITS = 11,
  parameter int unsigned PADDR_W   = 18,
  parameter int unsigned PTB_W     = 12
) (
  input  logic               clk,
  input  logic               rst,
  mmu_paged_if.slave         bus
`ifdef MMU_FAULT_REG_EN
  ,
  output logic               fault_pending,
  output logic [VADDR_W-1:0] fault_vaddr,
  input  logic               fault_clr
`endif
);
  localparam int unsigned VPN_W = VADDR_W - PAGE_BITS;
  localparam int unsigned PPN_W = PADDR_W - PAGE_BITS;
  localparam int unsigned ENT_W = PPN_W + 2;

  typedef enum logic [1:0] {
    CodeOk       = 2'd0,
    CodeInvalid  = 2'd1,
    CodeReadOnly = 2'd2
  } code_e;

  // Entry layout: {valid, writable, ppn}. Not reset; contents come from the RAM init image.
  logic [ENT_W-1:0] pt_mem [2**PTB_W];

  logic               req_ready;
  logic               accept;
  logic [VPN_W-1:0]   vpn;
  logic [PTB_W-1:0]   vpn_idx;
  logic [PTB_W-1:0]   idx;
  logic [ENT_W-1:0]   entry;
  logic               ent_valid;
  logic               ent_wr;
  logic [PPN_W-1:0]   ppn;
  code_e              lk_code;
  logic               lk_fault;
  logic [PADDR_W-1:0] lk_addr;

  logic               resp_valid_q, resp_valid_d;
  logic [PADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic               resp_fault_q, resp_fault_d;
  code_e              resp_code_q, resp_code_d;

  assign req_ready = !resp_valid_q || bus.resp_ready;
  assign accept    = bus.req_valid && req_ready && !rst;

  always_comb begin
    vpn     = bus.req_addr[VADDR_W-1:PAGE_BITS];
    vpn_idx = PTB_W'(vpn);
    idx     = bus.priv_lv ? (bus.ptb + vpn_idx) : vpn_idx;
    // Same-cycle write to the looked-up entry is forwarded so the response sees the new mapping.
    entry     = (bus.pt_we && (bus.pt_waddr == idx)) ? bus.pt_wdata : pt_mem[idx];
    ent_valid = entry[ENT_W-1];
    ent_wr    = entry[ENT_W-2];
    ppn       = entry[PPN_W-1:0];

    lk_code = CodeOk;
    if (bus.priv_lv) begin
      if (!ent_valid) begin
        lk_code = CodeInvalid;
      end else if (bus.req_write && !ent_wr) begin
        lk_code = CodeReadOnly;
      end
    end
    lk_fault = (lk_code != CodeOk);
    lk_addr  = lk_fault ? '0 : {ppn, bus.req_addr[PAGE_BITS-1:0]};
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_addr_d  = resp_addr_q;
    resp_fault_d = resp_fault_q;
    resp_code_d  = resp_code_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_addr_d  = lk_addr;
      resp_fault_d = lk_fault;
      resp_code_d  = lk_code;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_fault_q <= 1'b0;
      resp_code_q  <= CodeOk;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      resp_fault_q <= resp_fault_d;
      resp_code_q  <= resp_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.pt_we) begin
      pt_mem[bus.pt_waddr] <= bus.pt_wdata;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_addr  = resp_addr_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.resp_code  = resp_code_q;

`ifdef MMU_FAULT_REG_EN
  logic               fault_pending_q;
  logic [VADDR_W-1:0] fault_vaddr_q;

  // A new fault beats a simultaneous clear; otherwise the first address is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_pending_q <= 1'b0;
      fault_vaddr_q   <= '0;
    end else if (accept && lk_fault) begin
      fault_pending_q <= 1'b1;
      if (!fault_pending_q || fault_clr) begin
        fault_vaddr_q <= bus.req_addr;
      end
    end else if (fault_clr) begin
      fault_pending_q <= 1'b0;
    end
  end

  assign fault_pending = fault_pending_q;
  assign fault_vaddr   = fault_vaddr_q;
`endif
endmodule

// File: tb/tb_mmu_paged.sv
// Directed and randomized bench for mmu_paged against an arithmetic reference model.
module tb_mmu_paged;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [8:0]  model_pt [4096];
  logic        exp_v;
  logic [20:0] exp_bits;

  mmu_paged_if #(.VADDR_W(16), .PAGE_BITS(11), .PADDR_W(18), .PTB_W(12)) bus ();

`ifdef MMU_FAULT_REG_EN
  logic        fault_pending;
  logic [15:0] fault_vaddr;
  logic        fault_clr;
`endif

  mmu_paged #(.VADDR_W(16), .PAGE_BITS(11), .PADDR_W(18), .PTB_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MMU_FAULT_REG_EN
    ,
    .fault_pending (fault_pending),
    .fault_vaddr   (fault_vaddr),
    .fault_clr     (fault_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {fault, code[1:0], paddr[17:0]} from the table model.
  function automatic logic [20:0] model_xlate(input int addr, input bit wr, input bit priv,
                                              input int ptb);
    int vpn, idx, ent, ppn;
    vpn = addr / 2048;
    idx = priv ? (ptb + vpn) % 4096 : vpn;
    ent = int'(model_pt[idx]);
    ppn = ent % 128;
    if (priv && ((ent / 256) % 2 == 0)) return {1'b1, 2'd1, 18'd0};
    if (priv && wr && ((ent / 128) % 2 == 0)) return {1'b1, 2'd2, 18'd0};
    return {1'b0, 2'd0, 18'(ppn * 2048 + addr % 2048)};
  endfunction

  task automatic pt_write(input int idx, input logic [8:0] data);
    bus.pt_we    = 1'b1;
    bus.pt_waddr = 12'(idx);
    bus.pt_wdata = data;
    model_pt[idx] = data;
    step();
    bus.pt_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] addr, input bit wr, input bit priv, input logic [11:0] p);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.priv_lv   = priv;
    bus.ptb       = p;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input bit f, input int code, input int addr);
    check({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, "_fault"}, 32'(bus.resp_fault), 32'(f));
    check({tag, "_code"},  32'(bus.resp_code),  32'(code));
    check({tag, "_addr"},  32'(bus.resp_addr),  32'(addr));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.priv_lv = 1'b0;
    bus.ptb = '0; bus.resp_ready = 1'b1; bus.pt_we = 1'b0; bus.pt_waddr = '0; bus.pt_wdata = '0;
`ifdef MMU_FAULT_REG_EN
    fault_clr = 1'b0;
`endif
    step();
    step();
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_addr",  32'(bus.resp_addr),  32'd0);
    check("rst_fault", 32'(bus.resp_fault), 32'd0);
    check("rst_code",  32'(bus.resp_code),  32'd0);
    check("rst_ready", 32'(bus.req_ready),  32'd1);
    rst = 1'b0;

    for (int i = 0; i < 4096; i++) pt_write(i, 9'($urandom_range(0, 511)));

    // Sys mapping
    pt_write(3, 9'h1D5);
    send(16'h1ABC, 1'b0, 1'b0, 12'h000);
    expect_resp("sys_map", 1'b0, 0, 'h2AABC);

    // Usr with wrapping table base
    send(16'h2923, 1'b0, 1'b1, 12'hFFE);
    expect_resp("usr_wrap", 1'b0, 0, 'h2A923);

    // Invalid page
    pt_write(10, 9'h033);
    send(16'h5010, 1'b0, 1'b1, 12'h000);
    expect_resp("usr_inval", 1'b1, 1, 0);
`ifdef MMU_FAULT_REG_EN
    check("freg_set",   32'(fault_pending), 32'd1);
    check("freg_vaddr", 32'(fault_vaddr),   32'h5010);
`endif

    // Store to read-only page: usr faults, sys does not
    pt_write(11, 9'h144);
    send(16'h5807, 1'b1, 1'b1, 12'h000);
    expect_resp("usr_ro", 1'b1, 2, 0);
`ifdef MMU_FAULT_REG_EN
    check("freg_sticky", 32'(fault_vaddr), 32'h5010);
`endif
    send(16'h5807, 1'b1, 1'b0, 12'h000);
    expect_resp("sys_ro", 1'b0, 0, 'h22007);

`ifdef MMU_FAULT_REG_EN
    fault_clr = 1'b1;
    step();
    check("freg_clr", 32'(fault_pending), 32'd0);
    pt_write(3, 9'h1D5);
    send(16'h5010, 1'b0, 1'b1, 12'h000);
    send(16'h5811, 1'b1, 1'b1, 12'h000);
    fault_clr = 1'b0;
    check("freg_clr_set_p", 32'(fault_pending), 32'd1);
    check("freg_clr_set_a", 32'(fault_vaddr),   32'h5811);
`endif

    // Backpressure
    step();
    bus.resp_ready = 1'b0;
    send(16'h1ABC, 1'b0, 1'b0, 12'h000);
    bus.req_valid = 1'b1; bus.req_addr = 16'h2923; bus.priv_lv = 1'b1; bus.ptb = 12'hFFE;
    bus.req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      expect_resp("bp_hold", 1'b0, 0, 'h2AABC);
      step();
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_release", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    expect_resp("bp_next", 1'b0, 0, 'h2A923);

    // Write-during-lookup bypass
    pt_write(7, 9'h16E);
    bus.pt_we = 1'b1; bus.pt_waddr = 12'd7; bus.pt_wdata = 9'h192;
    model_pt[7] = 9'h192;
    send(16'h3845, 1'b0, 1'b0, 12'h000);
    bus.pt_we = 1'b0;
    expect_resp("bypass", 1'b0, 0, 'h9045);

    // Reset while a response is held
    bus.resp_ready = 1'b0;
    send(16'h5010, 1'b0, 1'b1, 12'h000);
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = 16'h2923; bus.priv_lv = 1'b1; bus.ptb = 12'hFFE;
    #1;
    check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("rst_mid_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mid_addr",  32'(bus.resp_addr),  32'd0);
    check("rst_mid_fault", 32'(bus.resp_fault), 32'd0);
    check("rst_mid_code",  32'(bus.resp_code),  32'd0);
`ifdef MMU_FAULT_REG_EN
    check("rst_freg_p", 32'(fault_pending), 32'd0);
    check("rst_freg_a", 32'(fault_vaddr),   32'd0);
`endif
    bus.resp_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    check("rst_req_drop", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    bus.req_valid = 1'b0;

    // Randomized traffic against the model
    exp_v = 1'b0;
    exp_bits = '0;
    for (int n = 0; n < 400; n++) begin
      int  addr, ptbv, idx;
      bit  rv, wr, priv, rr, we, accept;
      logic [8:0] wd;
      addr = int'($urandom_range(0, 65535));
      ptbv = int'($urandom_range(0, 4095));
      rv   = ($urandom_range(0, 3) != 0);
      wr   = 1'($urandom_range(0, 1));
      priv = 1'($urandom_range(0, 1));
      rr   = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 3) == 0);
      wd   = 9'($urandom_range(0, 511));
      idx  = priv ? (ptbv + addr / 2048) % 4096 : addr / 2048;
      if ($urandom_range(0, 1) == 0) idx = int'($urandom_range(0, 4095));
      bus.req_valid = rv; bus.req_addr = 16'(addr); bus.req_write = wr; bus.priv_lv = priv;
      bus.ptb = 12'(ptbv); bus.resp_ready = rr;
      bus.pt_we = we; bus.pt_waddr = 12'(idx); bus.pt_wdata = wd;
      #1;
      check("rnd_ready", 32'(bus.req_ready), 32'(!exp_v || rr));
      accept = rv && (!exp_v || rr);
      if (we) model_pt[idx] = wd;
      if (accept) begin
        exp_v = 1'b1;
        exp_bits = model_xlate(addr, wr, priv, ptbv);
      end else if (rr) begin
        exp_v = 1'b0;
      end
      step();
      check("rnd_valid", 32'(bus.resp_valid), 32'(exp_v));
      if (exp_v) begin
        check("rnd_fault", 32'(bus.resp_fault), 32'(exp_bits[20]));
        check("rnd_code",  32'(bus.resp_code),  32'(exp_bits[19:18]));
        check("rnd_addr",  32'(bus.resp_addr),  32'(exp_bits[17:0]));
      end
    end
    bus.req_valid = 1'b0;
    bus.pt_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
